uart_receive_fifo: RTL and testbench

Parametrised UART receiver for the Caravel user-project UART peripheral. It replaces the single-byte receiver. Additions over that receiver:
- runtime-selectable character length (5–8), parity and stop-bit count
- a 2-flop input synchroniser and false-start rejection
- a first-word-fall-through receive FIFO
- sticky framing, parity and overrun error flags

It sits between the `rx` pad and the Wishbone register file, which drives `read`, the configuration inputs and `err_clr`.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_receive_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_receive_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity modes and
// the character-length offset applied to the 2-bit char_len field.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned CHAR_LEN_OFFSET = 5;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Unused data bits are zero, so the XOR covers exactly the received bits.
  function automatic logic parity_expected(input logic [1:0] mode,
                                           input logic [7:0] data);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO. When empty, dout keeps the last
// popped word so a reader never sees stale RAM contents change under it.
module uart_sync_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == DEPTH_CNT);
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = empty ? r_last : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/uart_receive_fifo.sv
// UART receiver with configurable framing, input synchroniser, false-start
// rejection, FWFT receive FIFO, sticky error flags and a registered interrupt.
module uart_receive_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CNT_WIDTH-1:0]          clk_div,
  input  logic [1:0]                    char_len,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          rx,
  input  logic                          read,
  input  logic                          irq_en,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_par_bad;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 r_irq;

  logic [CNT_WIDTH-1:0] w_half_last;
  logic [CNT_WIDTH-1:0] w_full_last;
  logic                 w_term;
  logic [2:0]           w_last_idx;
  logic [7:0]           w_fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_overrun_set;

  // Idle-high line: synchroniser resets to 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_half_last = (clk_div >> 1) - CNT_ONE;
  assign w_full_last = clk_div - CNT_ONE;
  assign w_term      = (r_state == ST_START) ? (r_cnt == w_half_last)
                                             : (r_cnt == w_full_last);
  assign w_last_idx  = 3'(CHAR_LEN_OFFSET - 1) + {1'b0, char_len};

  // A full FIFO only drops the push when no pop frees a slot this cycle.
  assign w_overrun_set = r_push & w_fifo_full & ~read;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_par_bad    <= 1'b0;
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_cnt  <= w_term ? '0 : r_cnt + CNT_ONE;
      if (err_clr) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
        r_overrun    <= 1'b0;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_par_bad <= 1'b0;
          if (!r_rx_s) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_term) begin
            r_state <= r_rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_term) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == w_last_idx) begin
              r_state <= parity_enabled(parity_mode) ? ST_PARITY : ST_STOP1;
            end
          end
        end
        ST_PARITY: begin
          if (w_term) begin
            if (r_rx_s != parity_expected(parity_mode, r_shift)) begin
              r_par_bad <= 1'b1;
            end
            r_state <= ST_STOP1;
          end
        end
        ST_STOP1, ST_STOP2: begin
          if (w_term) begin
            if (!r_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end else if ((r_state == ST_STOP1) && two_stop) begin
              r_state <= ST_STOP2;
            end else begin
              r_state <= ST_IDLE;
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_push <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shift register is cleared while idle, so bits beyond char_len stay zero and
  // it still holds the finished character during the push cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE) begin
      r_shift <= '0;
    end else if ((r_state == ST_DATA) && w_term) begin
      r_shift[r_bit_idx] <= r_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= irq_en & (~w_fifo_empty | r_frame_err | r_parity_err | r_overrun);
    end
  end

  uart_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .pop   (read),
    .din   (r_shift),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign rx_data    = w_fifo_dout;
  assign rx_valid   = ~w_fifo_empty;
  assign fifo_level = w_fifo_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign irq        = r_irq;

endmodule

// File: tb/tb_uart_receive_fifo.sv
// Directed bench for uart_receive_fifo: serial frames driven bit by bit at
// clk_div = 16, outputs sampled on the falling clock edge.
module tb_uart_receive_fifo;

  localparam int DEPTH  = 4;
  localparam int CW     = 32;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int BITCLK = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] clk_div;
  logic [1:0]    char_len;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          rx;
  logic          read;
  logic          irq_en;
  logic          err_clr;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [LW-1:0] fifo_level;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          irq;

  int checks   = 0;
  int failures = 0;
  bit found;

  always #5 clk = ~clk;

  uart_receive_fifo #(
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_div     (clk_div),
    .char_len    (char_len),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rx          (rx),
    .read        (read),
    .irq_en      (irq_en),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fifo_level  (fifo_level),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .irq         (irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read();
    @(posedge clk); #1;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  // With 8 data bits, no parity, one stop bit, the final stop sample lands 11
  // edges into the stop bit; read asserted after that edge coincides with the push.
  task automatic send_frame(input logic [7:0] data, input int nbits, input int par,
                            input bit flip, input int nstop, input bit stop_low,
                            input bit rd_at_push);
    logic p;
    @(posedge clk); #1;
    rx = 1'b0;
    tick(BITCLK);
    for (int i = 0; i < nbits; i++) begin
      rx = data[i];
      tick(BITCLK);
    end
    if (par != 0) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      if (par == 2) p = ~p;
      rx = p ^ flip;
      tick(BITCLK);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = ~stop_low;
      for (int c = 0; c < BITCLK; c++) begin
        @(posedge clk); #1;
        read = rd_at_push && (s == nstop - 1) && (c == 10);
      end
      if (stop_low) return;
    end
    rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_div = 32'd16; char_len = 2'd3; parity_mode = 2'd0;
    two_stop = 1'b0; rx = 1'b1; read = 1'b0; irq_en = 1'b0; err_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_rx_data", rx_data, 8'h00);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_flags", {frame_err, parity_err, overrun}, 3'b000);
    check_val("rst_irq", irq, 0);

    // 8N1 0x55 with interrupt enabled
    irq_en = 1'b1;
    fork
      send_frame(8'h55, 8, 0, 1'b0, 1, 1'b0, 1'b0);
      begin
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          if (rx_valid) found = 1'b1;
        end
        check_val("valid_rise", found, 1);
        check_val("irq_same_cycle", irq, 0);
        @(negedge clk);
        check_val("irq_next_cycle", irq, 1);
      end
    join
    tick(4);
    @(negedge clk);
    check_val("8n1_data", rx_data, 8'h55);
    check_val("8n1_level", fifo_level, 1);
    do_read();
    @(negedge clk);
    check_val("pop_valid", rx_valid, 0);
    check_val("pop_level", fifo_level, 0);
    check_val("pop_irq_lag", irq, 1);
    @(negedge clk);
    check_val("pop_irq_clear", irq, 0);
    do_read();
    @(negedge clk);
    check_val("empty_read_data", rx_data, 8'h55);
    check_val("empty_read_level", fifo_level, 0);

    // false start: 5-cycle low glitch
    @(posedge clk); #1;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    @(negedge clk);
    check_val("glitch_level", fifo_level, 0);
    check_val("glitch_flags", {frame_err, parity_err, overrun}, 3'b000);
    send_frame(8'hA3, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check_val("after_glitch_data", rx_data, 8'hA3);
    do_read();

    // 7E2
    char_len = 2'd2; parity_mode = 2'd1; two_stop = 1'b1;
    send_frame(8'h41, 7, 1, 1'b0, 2, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check_val("7e2_data", rx_data, 8'h41);
    check_val("7e2_par_ok", parity_err, 0);
    do_read();
    send_frame(8'h41, 7, 1, 1'b1, 2, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check_val("7e2_par_bad", parity_err, 1);
    check_val("7e2_par_level", fifo_level, 0);
    pulse_err_clr();
    @(negedge clk);
    check_val("par_clr", parity_err, 0);
    char_len = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;

    // stop bit low, then break held for 3 bit times
    send_frame(8'h00, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("frame_err_set", frame_err, 1);
    pulse_err_clr();
    @(negedge clk);
    check_val("frame_err_clr", frame_err, 0);
    tick(3 * BITCLK);
    @(negedge clk);
    check_val("break_single_err", frame_err, 0);
    check_val("break_level", fifo_level, 0);
    @(posedge clk); #1;
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    check_val("break_end_err", frame_err, 0);
    check_val("break_end_valid", rx_valid, 0);

    // overrun: five bytes, no reads
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 8, 0, 1'b0, 1, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check_val("ovr_level", fifo_level, 4);
    check_val("ovr_flag", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val($sformatf("ovr_read%0d", k), rx_data, 32'(k));
      do_read();
    end
    @(negedge clk);
    check_val("ovr_drained", fifo_level, 0);
    pulse_err_clr();
    @(negedge clk);
    check_val("ovr_clr", overrun, 0);

    // full FIFO with read in the push cycle
    for (int b = 0; b < 4; b++) send_frame(8'h11 + 8'(b), 8, 0, 1'b0, 1, 1'b0, 1'b0);
    send_frame(8'h15, 8, 0, 1'b0, 1, 1'b0, 1'b1);
    tick(4);
    @(negedge clk);
    check_val("pp_overrun", overrun, 0);
    check_val("pp_level", fifo_level, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("pp_read%0d", k), rx_data, 32'h12 + 32'(k));
      do_read();
    end

    // reset mid-byte with a byte held and irq asserted
    send_frame(8'h77, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check_val("pre_rst_level", fifo_level, 1);
    check_val("pre_rst_irq", irq, 1);
    @(posedge clk); #1;
    rx = 1'b0;
    tick(30);
    rx = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_data", rx_data, 8'h00);
    check_val("mid_rst_valid", rx_valid, 0);
    check_val("mid_rst_level", fifo_level, 0);
    check_val("mid_rst_flags", {frame_err, parity_err, overrun}, 3'b000);
    check_val("mid_rst_irq", irq, 0);
    tick(40);
    @(negedge clk);
    check_val("post_rst_idle_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
